mcmult_issue_ctrl: RTL and testbench

//   Upstream issue/collection stage for the multi-cycle multiplier (mcmult2o). Accepts operand

---
 rtl/mcmult_issue_ctrl.sv | 124 ++++++++++++
 tb/tb_mcmult_issue_ctrl.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcmult_issue_ctrl.sv
// rtl/mcmult_issue_ctrl.sv - issue/collection stage for the multi-cycle multiplier
// Paces start pulses at the initiation interval and collects products into a credit-guarded FIFO.
module mcmult_issue_ctrl #(
   parameter int N     = 8,
   parameter int M     = 8,
   parameter int II    = 4,
   parameter int LAT   = 5,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sign,
   input  logic [N-1:0]     in_a,
   input  logic [M-1:0]     in_b,
   output logic             mul_start,
   output logic             mul_sign,
   output logic [N-1:0]     mul_a,
   output logic [M-1:0]     mul_b,
   input  logic [N+M-1:0]   mul_out,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [N+M-1:0]   res_data
);

   localparam int IIW = (II > 1) ? $clog2(II) : 1;
   localparam int CW  = $clog2(DEPTH + 1);
   localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [IIW-1:0] II_LOAD  = IIW'(II - 1);
   localparam logic [CW-1:0]  CRED_MAX = CW'(DEPTH);
   localparam logic [PW-1:0]  PTR_LAST = PW'(DEPTH - 1);

   logic [IIW-1:0]   ii_cnt;
   logic [CW-1:0]    credits;
   logic [LAT-1:0]   track;
   logic [N+M-1:0]   fifo_mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             accept;
   logic             push;
   logic             pop;

   // A credit is taken at accept, so every in-flight product already owns a FIFO slot.
   assign in_ready  = !rst && (ii_cnt == '0) && (credits != '0);
   assign accept    = in_valid && in_ready;
   assign push      = track[LAT-1];
   assign res_valid = (count != '0);
   assign pop       = res_valid && res_ready;
   assign res_data  = res_valid ? fifo_mem[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         mul_start <= 1'b0;
         mul_sign  <= 1'b0;
         mul_a     <= '0;
         mul_b     <= '0;
         ii_cnt    <= '0;
      end else begin
         mul_start <= accept;
         if (accept) begin
            mul_sign <= in_sign;
            mul_a    <= in_a;
            mul_b    <= in_b;
            ii_cnt   <= II_LOAD;
         end else if (ii_cnt != '0) begin
            ii_cnt <= ii_cnt - IIW'(1);
         end
      end
   end

   // One bit per multiplier stage; the top bit marks the cycle mul_out holds a fresh product.
   always_ff @(posedge clk) begin
      if (rst) begin
         track <= '0;
      end else begin
         track[0] <= mul_start;
         for (int i = 1; i < LAT; i++) begin
            track[i] <= track[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         credits <= CRED_MAX;
      end else begin
         case ({accept, pop})
            2'b10:   credits <= credits - CW'(1);
            2'b01:   credits <= credits + CW'(1);
            default: credits <= credits;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push) begin
         fifo_mem[wr_ptr] <= mul_out;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_mcmult_issue_ctrl.sv
// tb/tb_mcmult_issue_ctrl.sv - directed and randomized bench for mcmult_issue_ctrl
// A multiplier model drives mul_out; an accept-time/availability-time reference predicts outputs.
module tb_mcmult_issue_ctrl;

   localparam int N     = 8;
   localparam int M     = 8;
   localparam int II    = 4;
   localparam int LAT   = 5;
   localparam int DEPTH = 4;
   localparam int W     = N + M;

   logic          clk       = 1'b0;
   logic          rst       = 1'b1;
   logic          in_valid  = 1'b0;
   logic          in_sign   = 1'b0;
   logic [N-1:0]  in_a      = '0;
   logic [M-1:0]  in_b      = '0;
   logic          res_ready = 1'b0;
   logic          in_ready;
   logic          mul_start;
   logic          mul_sign;
   logic [N-1:0]  mul_a;
   logic [M-1:0]  mul_b;
   logic [W-1:0]  mul_out;
   logic          res_valid;
   logic [W-1:0]  res_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mcmult_issue_ctrl #(.N(N), .M(M), .II(II), .LAT(LAT), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sign   (in_sign),
      .in_a      (in_a),
      .in_b      (in_b),
      .mul_start (mul_start),
      .mul_sign  (mul_sign),
      .mul_a     (mul_a),
      .mul_b     (mul_b),
      .mul_out   (mul_out),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data)
   );

   function automatic logic [W-1:0] mul_fn(input logic s, input logic [N-1:0] a, input logic [M-1:0] b);
      longint pa;
      longint pb;
      pa = s ? longint'($signed(a)) : longint'(a);
      pb = s ? longint'($signed(b)) : longint'(b);
      return W'(pa * pb);
   endfunction

   // Multiplier: product of the operands seen with mul_start appears LAT cycles later.
   logic [W-1:0] mpipe [LAT];
   always @(posedge clk) begin
      mpipe[0] <= mul_start ? mul_fn(mul_sign, mul_a, mul_b) : W'(16'hDEAD);
      for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
   end
   assign mul_out = mpipe[LAT-1];

   // Reference: accepted ops become visible at accept_cycle+2+LAT, in order.
   typedef struct {
      logic [W-1:0] p;
      int           avail;
   } exp_t;

   exp_t          mq[$];
   int            cyc        = 0;
   int            last_acc   = -1000;
   int            outst      = 0;
   logic          m_ready_nr = 1'b0;
   logic          m_start    = 1'b0;
   logic          m_rv       = 1'b0;
   logic          m_sign     = 1'b0;
   logic [N-1:0]  m_a        = '0;
   logic [M-1:0]  m_b        = '0;
   logic [W-1:0]  m_rd       = '0;
   logic          m_in_ready;

   assign m_in_ready = !rst && m_ready_nr;

   initial forever begin
      logic acc;
      logic pp;
      exp_t e;
      @(posedge clk);
      acc = !rst && in_valid && m_ready_nr;
      pp  = !rst && m_rv && res_ready;
      if (rst) begin
         mq.delete();
         last_acc = -1000;
         outst    = 0;
         m_start  = 1'b0;
         m_sign   = 1'b0;
         m_a      = '0;
         m_b      = '0;
      end else begin
         if (pp) begin
            void'(mq.pop_front());
            outst--;
         end
         if (acc) begin
            e.p     = mul_fn(in_sign, in_a, in_b);
            e.avail = cyc + 2 + LAT;
            mq.push_back(e);
            last_acc = cyc;
            outst++;
            m_sign = in_sign;
            m_a    = in_a;
            m_b    = in_b;
         end
         m_start = acc;
      end
      cyc++;
      m_ready_nr = (cyc - last_acc >= II) && (outst < DEPTH);
      m_rv       = (mq.size() > 0) && (mq[0].avail <= cyc);
      m_rd       = m_rv ? mq[0].p : '0;
   end

   task automatic cyc_drive(input logic r, input logic v, input logic s,
                            input logic [N-1:0] a, input logic [M-1:0] b, input logic rr);
      @(negedge clk);
      rst = r; in_valid = v; in_sign = s; in_a = a; in_b = b; res_ready = rr;
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc_drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         cyc_drive(1'b1, 1'b1, 1'b1, 8'h55, 8'h66, 1'b1);
         checks++;
         if ({in_ready, res_valid, mul_start, mul_sign} !== 4'b0 || res_data !== '0 ||
             mul_a !== '0 || mul_b !== '0) begin
            errors++;
            $display("FAIL reset_state i=%0d got rdy=%b rv=%b st=%b sg=%b a=%h b=%h rd=%h exp all zero",
                     i, in_ready, res_valid, mul_start, mul_sign, mul_a, mul_b, res_data);
         end
      end
      cyc_drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready got %b exp 1", in_ready);
      end
   endtask

   task automatic run_one(input string name, input logic s, input logic [N-1:0] a,
                          input logic [M-1:0] b, input logic [W-1:0] expv);
      idle(12);
      cyc_drive(1'b0, 1'b1, s, a, b, 1'b0);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s_accept got in_ready=%b exp 1", name, in_ready);
      end
      cyc_drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
      checks++;
      if (mul_start !== 1'b1 || mul_a !== a || mul_b !== b || mul_sign !== s) begin
         errors++;
         $display("FAIL %s_issue got st=%b a=%h b=%h sg=%b exp 1 %h %h %b",
                  name, mul_start, mul_a, mul_b, mul_sign, a, b, s);
      end
      for (int k = 2; k <= 7; k++) begin
         cyc_drive(1'b0, 1'b0, 1'b0, '0, '0, (k == 7));
         checks++;
         if (mul_start !== 1'b0 || res_valid !== (k == 7)) begin
            errors++;
            $display("FAIL %s_timing c0+%0d got st=%b rv=%b exp st=0 rv=%b",
                     name, k, mul_start, res_valid, (k == 7));
         end
      end
      checks++;
      if (res_data !== expv) begin
         errors++;
         $display("FAIL %s_data got %h exp %h", name, res_data, expv);
      end
      cyc_drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
      checks++;
      if (res_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s_popped got rv=%b exp 0", name, res_valid);
      end
   endtask

   task automatic test_basic();
      run_one("unsigned_200x3", 1'b0, 8'd200, 8'd3, 16'd600);
   endtask

   task automatic test_sign();
      run_one("signed_fdx05", 1'b1, 8'hFD, 8'h05, 16'hFFF1);
      run_one("unsigned_fdx05", 1'b0, 8'hFD, 8'h05, 16'h04F1);
   endtask

   task automatic test_back_to_back();
      int acc_q[$];
      int pop_q[$];
      idle(12);
      for (int i = 0; i < 44; i++) begin
         cyc_drive(1'b0, (i < 32), 1'($urandom_range(0, 1)), N'($urandom), M'($urandom), 1'b1);
         checks++;
         if (in_ready !== m_in_ready || mul_start !== m_start) begin
            errors++;
            $display("FAIL b2b_ctrl i=%0d got rdy=%b st=%b exp %b %b", i, in_ready, mul_start, m_in_ready, m_start);
         end
         checks++;
         if (res_valid !== m_rv || (m_rv && res_data !== m_rd)) begin
            errors++;
            $display("FAIL b2b_res i=%0d got rv=%b rd=%h exp %b %h", i, res_valid, res_data, m_rv, m_rd);
         end
         if (in_valid && in_ready) acc_q.push_back(i);
         if (res_valid) pop_q.push_back(i);
      end
      checks++;
      if (acc_q.size() != 8 || pop_q.size() != 8) begin
         errors++;
         $display("FAIL b2b_counts got acc=%0d pop=%0d exp 8 8", acc_q.size(), pop_q.size());
      end
      for (int j = 0; j < acc_q.size() && j < pop_q.size(); j++) begin
         checks++;
         if (acc_q[j] != j * II || pop_q[j] != j * II + 2 + LAT) begin
            errors++;
            $display("FAIL b2b_spacing j=%0d got acc=%0d pop=%0d exp %0d %0d",
                     j, acc_q[j], pop_q[j], j * II, j * II + 2 + LAT);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] expq[$];
      int acc = 0;
      int drained = 0;
      logic [W-1:0] e;
      idle(12);
      for (int i = 0; i < 60; i++) begin
         cyc_drive(1'b0, (i <= 31), 1'($urandom_range(0, 1)), N'($urandom), M'($urandom),
                   (i == 30) || (i >= 32));
         if (i == 29 || i == 30) begin
            checks++;
            if (in_ready !== 1'b0 || acc != DEPTH) begin
               errors++;
               $display("FAIL bp_full i=%0d got rdy=%b acc=%0d exp 0 %0d", i, in_ready, acc, DEPTH);
            end
         end
         if (i == 31) begin
            checks++;
            if (in_ready !== 1'b1) begin
               errors++;
               $display("FAIL bp_credit_return got rdy=%b exp 1", in_ready);
            end
         end
         if (in_valid && in_ready) begin
            acc++;
            expq.push_back(mul_fn(in_sign, in_a, in_b));
         end
         if (res_valid && res_ready) begin
            e = (expq.size() > 0) ? expq.pop_front() : 'x;
            drained++;
            checks++;
            if (res_data !== e) begin
               errors++;
               $display("FAIL bp_order n=%0d got %h exp %h", drained, res_data, e);
            end
         end
      end
      checks++;
      if (acc != 5 || drained != 5) begin
         errors++;
         $display("FAIL bp_drain got acc=%0d drained=%0d exp 5 5", acc, drained);
      end
   endtask

   task automatic test_pop_accept_same();
      logic [W-1:0] expq[$];
      int acc = 0;
      int late = 0;
      logic [W-1:0] e;
      logic v;
      idle(12);
      for (int i = 0; i < 60; i++) begin
         v = (i < 20) ? (acc < 3) : (i == 20 || i == 24);
         cyc_drive(1'b0, v, 1'($urandom_range(0, 1)), N'($urandom), M'($urandom),
                   (i == 20) || (i >= 35));
         if (i == 20) begin
            checks++;
            if (in_ready !== 1'b1 || res_valid !== 1'b1) begin
               errors++;
               $display("FAIL same_cycle_setup got rdy=%b rv=%b exp 1 1", in_ready, res_valid);
            end
         end
         if (i >= 21 && i <= 23) begin
            checks++;
            if (in_ready !== 1'b0) begin
               errors++;
               $display("FAIL same_cycle_ii i=%0d got rdy=%b exp 0", i, in_ready);
            end
         end
         if (i == 24) begin
            checks++;
            if (in_ready !== 1'b1) begin
               errors++;
               $display("FAIL same_cycle_credit_kept got rdy=%b exp 1", in_ready);
            end
         end
         if (i == 30) begin
            checks++;
            if (in_ready !== 1'b0) begin
               errors++;
               $display("FAIL same_cycle_credit_zero got rdy=%b exp 0", in_ready);
            end
         end
         if (in_valid && in_ready) begin
            acc++;
            expq.push_back(mul_fn(in_sign, in_a, in_b));
         end
         if (res_valid && res_ready) begin
            e = (expq.size() > 0) ? expq.pop_front() : 'x;
            if (i >= 35) late++;
            checks++;
            if (res_data !== e) begin
               errors++;
               $display("FAIL same_cycle_data i=%0d got %h exp %h", i, res_data, e);
            end
         end
      end
      checks++;
      if (acc != 5 || late != 4) begin
         errors++;
         $display("FAIL same_cycle_count got acc=%0d drained=%0d exp 5 4", acc, late);
      end
   endtask

   task automatic test_mid_reset();
      int seen = 0;
      int acc = 0;
      idle(12);
      cyc_drive(1'b0, 1'b1, 1'b0, 8'd77, 8'd9, 1'b1);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL midrst_accept got rdy=%b exp 1", in_ready);
      end
      cyc_drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
      cyc_drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
      cyc_drive(1'b1, 1'b1, 1'b0, 8'd1, 8'd1, 1'b1);
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL midrst_during got rdy=%b exp 0", in_ready);
      end
      cyc_drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
      checks++;
      if (in_ready !== 1'b1 || mul_a !== '0 || mul_b !== '0) begin
         errors++;
         $display("FAIL midrst_after got rdy=%b a=%h b=%h exp 1 00 00", in_ready, mul_a, mul_b);
      end
      for (int i = 0; i < 15; i++) begin
         cyc_drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
         if (res_valid) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL midrst_dropped got %0d valid cycles exp 0", seen);
      end
      for (int i = 0; i < 24; i++) begin
         cyc_drive(1'b0, 1'b1, 1'b0, N'($urandom), M'($urandom), 1'b0);
         if (in_valid && in_ready) acc++;
      end
      checks++;
      if (acc != DEPTH) begin
         errors++;
         $display("FAIL midrst_credits got %0d accepts exp %0d", acc, DEPTH);
      end
      idle(30);
   endtask

   task automatic test_random();
      idle(12);
      for (int i = 0; i < 400; i++) begin
         cyc_drive(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   N'($urandom), M'($urandom), ($urandom_range(0, 3) != 0));
         checks++;
         if (in_ready !== m_in_ready || mul_start !== m_start) begin
            errors++;
            $display("FAIL rand_ctrl i=%0d got rdy=%b st=%b exp %b %b", i, in_ready, mul_start, m_in_ready, m_start);
         end
         checks++;
         if ({mul_sign, mul_a, mul_b} !== {m_sign, m_a, m_b}) begin
            errors++;
            $display("FAIL rand_operands i=%0d got %b %h %h exp %b %h %h",
                     i, mul_sign, mul_a, mul_b, m_sign, m_a, m_b);
         end
         checks++;
         if (res_valid !== m_rv || res_data !== m_rd) begin
            errors++;
            $display("FAIL rand_res i=%0d got rv=%b rd=%h exp %b %h", i, res_valid, res_data, m_rv, m_rd);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_sign();
      test_back_to_back();
      test_backpressure();
      test_pop_accept_same();
      test_mid_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
